// File: rtl/pll_lock_sequencer_if.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer_if
//   Groups the PLL-facing and system-facing signals of the lock sequencer.
//   master : the sequencer (consumes PLL_LOCK, drives everything else)
//   slave  : the PLL / system side
//
//   PLL_LOCK    PLL LOCK indication, asynchronous to the sequencer clock
//   PLL_RESETB  active-low reset to the PLL
//   SYS_RESET   active-high reset for the 64 MHz domain (consumers resync it)
//   READY       high only while the sequencer is in RUN
//   RETRY_CNT   saturating count of lock timeouts and lock losses
//   STATE       current sequencer state, debug visibility only
// ---------------------------------------------------------------------------
interface pll_lock_sequencer_if;
    logic       PLL_LOCK;
    logic       PLL_RESETB;
    logic       SYS_RESET;
    logic       READY;
    logic [7:0] RETRY_CNT;
    logic [2:0] STATE;

    modport master (
        input  PLL_LOCK,
        output PLL_RESETB, SYS_RESET, READY, RETRY_CNT, STATE
    );

    modport slave (
        output PLL_LOCK,
        input  PLL_RESETB, SYS_RESET, READY, RETRY_CNT, STATE
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
//   Bring-up and supervision of the 16->64 MHz PLL. Runs on the 16 MHz
//   reference clock: pulses the PLL reset, waits for LOCK, requires LOCK to
//   stay up for LOCK_STABLE cycles, then holds the system reset for a further
//   RST_STRETCH cycles before declaring RUN. A lock timeout or lock loss
//   re-runs the PLL reset and bumps a saturating retry counter.
//
// Ports
//   CLK    in   16 MHz reference clock (only clock of this block)
//   RESET  in   synchronous active-high reset, highest priority
//   bus    master modport of pll_lock_sequencer_if (see interface header)
//
// Parameters
//   PLL_RST_CYCLES  cycles PLL_RESETB is held low per attempt   (>= 2)
//   LOCK_TIMEOUT    cycles to wait for lock before retrying     (>= 2)
//   LOCK_STABLE     consecutive synchronised-lock cycles needed (>= 2)
//   RST_STRETCH     extra SYS_RESET cycles after qualification  (>= 2)
//   CNT_W           shared counter width, all counts <= 2**CNT_W
// ---------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 16384,
    parameter int LOCK_STABLE    = 256,
    parameter int RST_STRETCH    = 64,
    parameter int CNT_W          = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    pll_lock_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_PLLRST  = 3'd0,
        S_WAIT    = 3'd1,
        S_STABLE  = 3'd2,
        S_STRETCH = 3'd3,
        S_RUN     = 3'd4
    } state_e;

    // Terminal values of the shared counter, one per timed state.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(RST_STRETCH - 1);

    localparam logic [7:0] RETRY_MAX = 8'hFF;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic             retry_inc;

    logic [1:0]       lock_sync_q;
    logic             lock_s;

    logic             pll_resetb_q, pll_resetb_d;
    logic             sys_reset_q,  sys_reset_d;
    logic             ready_q,      ready_d;

    // -----------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous PLL LOCK. Cleared on RESET
    // so a stale lock from before the reset can never qualify a new attempt.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            lock_sync_q <= 2'b00;
        end else begin
            lock_sync_q <= {lock_sync_q[0], bus.PLL_LOCK};
        end
    end

    assign lock_s = lock_sync_q[1];

    // -----------------------------------------------------------------------
    // State register, shared counter, retry counter and registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_PLLRST;
            cnt_q        <= '0;
            retry_q      <= '0;
            pll_resetb_q <= 1'b0;
            sys_reset_q  <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            pll_resetb_q <= pll_resetb_d;
            sys_reset_q  <= sys_reset_d;
            ready_q      <= ready_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. In every lock-sensitive state the lock check is
    // evaluated before the terminal count, so a lock drop landing on the
    // terminal cycle still aborts instead of advancing.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;

        case (state_q)
            S_PLLRST: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = S_PLLRST;
                    retry_inc = 1'b1;
                end
            end
            S_STABLE: begin
                // A drop while qualifying is treated as a glitch: keep the PLL
                // running and simply re-wait, without counting a retry.
                if (!lock_s) begin
                    state_d = S_WAIT;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_STRETCH;
                end
            end
            S_STRETCH: begin
                if (!lock_s) begin
                    state_d   = S_PLLRST;
                    retry_inc = 1'b1;
                end else if (cnt_q == STRETCH_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_d   = S_PLLRST;
                    retry_inc = 1'b1;
                end
            end
            default: begin
                state_d = S_PLLRST;
            end
        endcase

        // Counter restarts on every state change. RUN has no terminal count,
        // so the counter is frozen there rather than left to wrap.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == S_RUN) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (retry_inc && (retry_q != RETRY_MAX)) begin
            retry_d = retry_q + 8'd1;
        end else begin
            retry_d = retry_q;
        end
    end

    // -----------------------------------------------------------------------
    // Output decode. Decoding the next state and registering it makes the
    // flopped outputs always match the state held in state_q, glitch-free.
    // -----------------------------------------------------------------------
    always_comb begin
        pll_resetb_d = (state_d != S_PLLRST);
        sys_reset_d  = (state_d != S_RUN);
        ready_d      = (state_d == S_RUN);
    end

    assign bus.PLL_RESETB = pll_resetb_q;
    assign bus.SYS_RESET  = sys_reset_q;
    assign bus.READY      = ready_q;
    assign bus.RETRY_CNT  = retry_q;
    assign bus.STATE      = state_q;

endmodule
